pipe_stage_skid: RTL and testbench

Parametrised, elastic pipeline-stage register: the successor to the fixed EX/MEM latch. It carries a control vector, a data word and a destination-register vector between any two pipeline stages. It adds a valid/ready handshake, a two-entry skid buffer so back-pressure never drops a beat, synchronous flush for branch/hazard kills, and asynchronous reset. Instantiated between EX and MEM first; ID/EX and MEM/WB reuse it with different parameters.

---
 rtl/pipe_stage_skid_pkg.sv | 27 ++
 rtl/pipe_stage_skid_if.sv | 18 +
 rtl/pipe_stage_skid_payload.sv | 15 +
 rtl/pipe_stage_skid.sv | 103 ++++++++++
 tb/tb_pipe_stage_skid.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// Shared types and constants for the elastic pipeline-stage register.
// Control-bit indices match the layout of the old EX/MEM control vector.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } stage_state_t;

   localparam int CTRL_WBS     = 0;
   localparam int CTRL_MM      = 1;
   localparam int CTRL_MEMDATA = 2;
   localparam int CTRL_WM      = 3;
   localparam int CTRL_NI      = 4;
   localparam int CTRL_WME     = 5;

   localparam int DEF_CTRL_W   = 7;
   localparam int DEF_DATA_W   = 16;
   localparam int DEF_DEST_W   = 5;
   localparam int DEF_NUM_DEST = 2;

   function automatic int payload_w(int ctrl_w, int data_w, int dest_w, int num_dest);
      return ctrl_w + data_w + dest_w * num_dest;
   endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready beat bundle: control vector, data word and destination indices.
interface pipe_stage_skid_if
   import pipe_pkg::*;
#(
   parameter int CTRL_W   = DEF_CTRL_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int DEST_W   = DEF_DEST_W,
   parameter int NUM_DEST = DEF_NUM_DEST
);
   logic                       valid;
   logic                       ready;
   logic [CTRL_W-1:0]          ctrl;
   logic [DATA_W-1:0]          data;
   logic [DEST_W*NUM_DEST-1:0] dest;

   modport master (output valid, ctrl, data, dest, input ready);
   modport slave  (input valid, ctrl, data, dest, output ready);
endinterface

// File: rtl/pipe_stage_skid_payload.sv
// One payload entry (ctrl+data+dest) with load enable and async clear.
module pipe_payload_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       q <= '0;
      else if (load) q <= d;
   end
endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a two-entry skid buffer and flush.
// The main entry drives the outputs; the skid entry catches the one beat accepted on the way into SKID.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int CTRL_W      = DEF_CTRL_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int DEST_W      = DEF_DEST_W,
   parameter int NUM_DEST    = DEF_NUM_DEST,
   parameter bit ZERO_BUBBLE = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   pipe_stage_skid_if.slave   up,
   pipe_stage_skid_if.master  dn,
   output logic [1:0]         occ
);
   localparam int DSW = DEST_W * NUM_DEST;
   localparam int PW  = payload_w(CTRL_W, DATA_W, DEST_W, NUM_DEST);

   stage_state_t    state, state_nxt;
   logic            in_rdy_q;
   logic            in_xfer, out_xfer, out_valid;
   logic            main_ld, skid_ld, main_from_skid;
   logic [PW-1:0]   in_pay, main_d, main_q, skid_q;
   logic [CTRL_W-1:0] main_ctrl;

   assign in_pay    = {up.ctrl, up.data, up.dest};
   assign out_valid = (state != EMPTY);
   assign in_xfer   = up.valid & in_rdy_q;
   assign out_xfer  = out_valid & dn.ready;

   always_comb begin
      state_nxt      = state;
      main_ld        = 1'b0;
      skid_ld        = 1'b0;
      main_from_skid = 1'b0;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: if (in_xfer) begin
               state_nxt = FULL;
               main_ld   = 1'b1;
            end
            FULL: case ({in_xfer, out_xfer})
               2'b11: main_ld = 1'b1;
               2'b10: begin
                  state_nxt = SKID;
                  skid_ld   = 1'b1;
               end
               2'b01: state_nxt = EMPTY;
               default: ;
            endcase
            SKID: if (out_xfer) begin
               state_nxt      = FULL;
               main_ld        = 1'b1;
               main_from_skid = 1'b1;
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   // in_ready is a flop so upstream never sees a combinational path from out_ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= EMPTY;
         in_rdy_q <= 1'b1;
      end else begin
         state    <= state_nxt;
         in_rdy_q <= (state_nxt != SKID);
      end
   end

   assign main_d = main_from_skid ? skid_q : in_pay;

   pipe_payload_reg #(.W(PW)) u_main (
      .clk(clk), .rst(rst), .load(main_ld), .d(main_d), .q(main_q)
   );

   pipe_payload_reg #(.W(PW)) u_skid (
      .clk(clk), .rst(rst), .load(skid_ld), .d(in_pay), .q(skid_q)
   );

   assign main_ctrl = main_q[PW-1 -: CTRL_W];
   assign dn.data   = main_q[DSW +: DATA_W];
   assign dn.dest   = main_q[DSW-1:0];
   assign dn.valid  = out_valid;
   assign up.ready  = in_rdy_q;
   assign occ       = state;

   // Bubbles carry no write/memory enables downstream when gating is on.
   generate
      if (ZERO_BUBBLE) begin : g_zb
         assign dn.ctrl = out_valid ? main_ctrl : '0;
      end else begin : g_raw
         assign dn.ctrl = main_ctrl;
      end
   endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus randomized traffic against a FIFO model.
module tb_pipe_stage_skid;
   import pipe_pkg::*;

   localparam int CW = 7, DW = 16, DSW = 5, ND = 2;
   localparam int PW = CW + DW + DSW * ND;

   logic clk = 1'b0;
   logic rst, flush, flush2;
   logic [1:0] occ, occ2;
   always #5 clk = ~clk;

   pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW), .DEST_W(DSW), .NUM_DEST(ND)) up (), dn ();
   pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(32), .DEST_W(DSW), .NUM_DEST(1)) up2 (), dn2 ();

   pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .DEST_W(DSW), .NUM_DEST(ND), .ZERO_BUBBLE(1'b1)) dut (
      .clk(clk), .rst(rst), .flush(flush), .up(up.slave), .dn(dn.master), .occ(occ)
   );

   pipe_stage_skid #(.CTRL_W(CW), .DATA_W(32), .DEST_W(DSW), .NUM_DEST(1), .ZERO_BUBBLE(1'b0)) dut2 (
      .clk(clk), .rst(rst), .flush(flush2), .up(up2.slave), .dn(dn2.master), .occ(occ2)
   );

   // Reference: the stage is a FIFO of depth 2; a flush empties it.
   logic [PW-1:0] q[$];
   int n_tests = 0, n_fail = 0;

   function automatic logic [DW-1:0] exp_data();
      return (q.size() > 0) ? q[0][DSW*ND +: DW] : '0;
   endfunction

   task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input logic [DSW*ND-1:0] ds);
      up.valid = v; up.ctrl = c; up.data = d; up.dest = ds;
   endtask

   // Advance one clock and update the model from what the handshake rules say happened.
   task automatic cyc();
      bit ix, ox, fl;
      logic [PW-1:0] pay;
      ix  = up.valid && (q.size() < 2);
      ox  = dn.ready && (q.size() > 0);
      fl  = flush;
      pay = {up.ctrl, up.data, up.dest};
      @(posedge clk);
      if (fl) q.delete();
      else begin
         if (ox) void'(q.pop_front());
         if (ix) q.push_back(pay);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_tests++; if (dn.valid !== 1'b0 || occ !== 2'd0 || up.ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_state valid=%b occ=%0d ready=%b exp 0/0/1", dn.valid, occ, up.ready);
      end
      n_tests++; if (dn.ctrl !== '0 || dn.data !== '0 || dn.dest !== '0) begin
         n_fail++; $display("FAIL reset_payload ctrl=%h data=%h dest=%h exp 0", dn.ctrl, dn.data, dn.dest);
      end
      rst = 1'b0;
      dn.ready = 1'b0;
      drive(1'b1, 7'h3F, 16'h0C01, 10'h021); cyc();
      drive(1'b1, 7'h3F, 16'h0C02, 10'h022); cyc();
      drive(1'b0, '0, '0, '0);
      n_tests++; if (occ !== 2'd2) begin
         n_fail++; $display("FAIL reset_prefill occ=%0d exp 2", occ);
      end
      #2 rst = 1'b1;
      #1;
      n_tests++; if (dn.valid !== 1'b0 || occ !== 2'd0 || up.ready !== 1'b1 || dn.ctrl !== '0) begin
         n_fail++; $display("FAIL reset_async valid=%b occ=%0d ready=%b ctrl=%h exp 0/0/1/0",
                            dn.valid, occ, up.ready, dn.ctrl);
      end
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_stream();
      dn.ready = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         if (i <= 16) drive(1'b1, 7'h01, 16'(i), 10'(i));
         else         drive(1'b0, '0, '0, '0);
         if (i > 1) begin
            n_tests++; if (dn.valid !== 1'b1 || dn.data !== 16'(i-1) || occ !== 2'd1) begin
               n_fail++; $display("FAIL stream_%0d valid=%b data=%h occ=%0d exp 1/%h/1",
                                  i-1, dn.valid, dn.data, occ, 16'(i-1));
            end
         end
         cyc();
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] got[$];
      logic [DW-1:0] exp [3] = '{16'h00A1, 16'h00A2, 16'h00A3};
      dn.ready = 1'b1;
      drive(1'b1, '0, 16'h00A1, '0); cyc();
      if (dn.valid && dn.ready) got.push_back(dn.data);
      drive(1'b1, '0, 16'h00A2, '0); cyc();
      dn.ready = 1'b0;
      drive(1'b1, '0, 16'h00A3, '0); cyc();
      drive(1'b0, '0, '0, '0);
      n_tests++; if (occ !== 2'd2 || up.ready !== 1'b0) begin
         n_fail++; $display("FAIL bp_full occ=%0d ready=%b exp 2/0", occ, up.ready);
      end
      cyc();
      n_tests++; if (occ !== 2'd2 || dn.data !== 16'h00A2) begin
         n_fail++; $display("FAIL bp_hold occ=%0d data=%h exp 2/00a2", occ, dn.data);
      end
      dn.ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (dn.valid && dn.ready) got.push_back(dn.data);
         cyc();
      end
      n_tests++; if (got.size() != 3) begin
         n_fail++; $display("FAIL bp_count got %0d beats exp 3", got.size());
      end
      for (int i = 0; i < 3; i++) begin
         n_tests++; if (got.size() <= i || got[i] !== exp[i]) begin
            n_fail++; $display("FAIL bp_order_%0d got %h exp %h", i, (got.size() > i) ? got[i] : 16'hxxxx, exp[i]);
         end
      end
   endtask

   task automatic test_flush();
      dn.ready = 1'b0;
      drive(1'b1, 7'h11, 16'h00B1, '0); cyc();
      drive(1'b1, 7'h11, 16'h00B2, '0); cyc();
      drive(1'b1, 7'h11, 16'h00B3, '0);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      drive(1'b0, '0, '0, '0);
      n_tests++; if (occ !== 2'd0 || dn.valid !== 1'b0 || up.ready !== 1'b1) begin
         n_fail++; $display("FAIL flush_skid occ=%0d valid=%b ready=%b exp 0/0/1", occ, dn.valid, up.ready);
      end
      dn.ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_tests++; if (dn.valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_leak valid=%b data=%h exp no beat", dn.valid, dn.data);
         end
         cyc();
      end
      drive(1'b1, 7'h11, 16'h00B4, '0);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      drive(1'b0, '0, '0, '0);
      n_tests++; if (occ !== 2'd0 || dn.valid !== 1'b0) begin
         n_fail++; $display("FAIL flush_empty occ=%0d valid=%b exp 0/0", occ, dn.valid);
      end
   endtask

   task automatic test_bubble();
      dn.ready = 1'b1;
      drive(1'b1, 7'h3F, 16'h3F3F, 10'h155); cyc();
      drive(1'b0, '0, '0, '0);
      n_tests++; if (dn.ctrl !== 7'h3F || dn.data !== 16'h3F3F) begin
         n_fail++; $display("FAIL bubble_beat ctrl=%h data=%h exp 3f/3f3f", dn.ctrl, dn.data);
      end
      cyc();
      n_tests++; if (dn.valid !== 1'b0 || dn.ctrl !== 7'h00 || dn.data !== 16'h3F3F) begin
         n_fail++; $display("FAIL bubble_gate valid=%b ctrl=%h data=%h exp 0/00/3f3f", dn.valid, dn.ctrl, dn.data);
      end
   endtask

   task automatic test_params();
      up2.valid = 1'b1; up2.ctrl = 7'h55; up2.data = 32'hDEADBEEF; up2.dest = 5'd17;
      dn2.ready = 1'b0;
      @(posedge clk); @(negedge clk);
      up2.valid = 1'b0; up2.data = '0; up2.dest = '0; up2.ctrl = '0;
      n_tests++; if (dn2.valid !== 1'b1 || dn2.data !== 32'hDEADBEEF || dn2.dest !== 5'd17 || occ2 !== 2'd1) begin
         n_fail++; $display("FAIL param_beat valid=%b data=%h dest=%0d occ=%0d exp 1/deadbeef/17/1",
                            dn2.valid, dn2.data, dn2.dest, occ2);
      end
      dn2.ready = 1'b1;
      @(posedge clk); @(negedge clk);
      n_tests++; if (dn2.valid !== 1'b0 || dn2.ctrl !== 7'h55) begin
         n_fail++; $display("FAIL param_nogate valid=%b ctrl=%h exp 0/55", dn2.valid, dn2.ctrl);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         drive(($urandom % 4) != 0, 7'($urandom), 16'($urandom), 10'($urandom));
         dn.ready = ($urandom % 3) != 0;
         flush    = ($urandom % 29) == 0;
         n_tests++; if (occ !== 2'(q.size()) || dn.valid !== (q.size() != 0) || up.ready !== (q.size() < 2)) begin
            n_fail++; $display("FAIL rnd_state_%0d occ=%0d valid=%b ready=%b exp occ %0d", n, occ, dn.valid, up.ready, q.size());
         end
         if (q.size() > 0) begin
            n_tests++; if ({dn.ctrl, dn.data, dn.dest} !== q[0]) begin
               n_fail++; $display("FAIL rnd_beat_%0d got %h exp %h", n, {dn.ctrl, dn.data, dn.dest}, q[0]);
            end
         end else begin
            n_tests++; if (dn.ctrl !== '0) begin
               n_fail++; $display("FAIL rnd_bubble_%0d ctrl=%h exp 0 (data %h)", n, dn.ctrl, exp_data());
            end
         end
         cyc();
      end
      flush = 1'b0;
      drive(1'b0, '0, '0, '0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; flush2 = 1'b0;
      drive(1'b0, '0, '0, '0);
      dn.ready = 1'b0;
      up2.valid = 1'b0; up2.ctrl = '0; up2.data = '0; up2.dest = '0;
      dn2.ready = 1'b0;
      test_reset();
      test_stream();
      test_back_to_back();
      test_flush();
      test_bubble();
      test_params();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
